simon_seq_ctrl: RTL and testbench
=================================

Name: simon_seq_ctrl

Overview:
- Round-sequencing controller for the pattern-memory game.
- Each round it appends one random one-hot LED pattern to the external sequence store, then plays the whole stored sequence on the LEDs.
- It then accepts the player's switch entries one per BTN press and compares each against the stored step.
- It ends the game with WIN or FAIL, and sits between the debounced button/switch inputs, the sequence store and the LED driver.

Parameters:
- MAX_LEN, 16, number of rounds to win; maximum sequence length (power of 2 not required, 2..256).
- SHOW_CYCLES, 50_000_000, CLK cycles each step's pattern is displayed.
- GAP_CYCLES, 12_500_000, CLK cycles of dark display between steps and after the last step.
- LFSR_SEED, 8'hA5, nonzero reset value of the pattern LFSR.
- TIMEOUT_CYCLES, 500_000_000, input timeout; used only with SIMON_TIMEOUT_EN.
- Derived, not overridable: AW = max(1, $clog2(MAX_LEN)).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse, already debounced; starts or restarts a game.
- BTN  in  1  one-cycle pulse, already debounced; submits LEDS as the player's entry.
- LEDS  in  8  player switch value.
- MEM_WE  out  1  sequence-store write strobe.
- MEM_ADDR  out  AW  sequence-store address, shared by read and write.
- MEM_WDATA  out  8  pattern to write.
- MEM_RDATA  in  8  store read data, valid the cycle after MEM_ADDR is presented (synchronous read).
- DISP  out  8  pattern to drive on LEDs.
- LD  out  1  high while DISP shows a sequence step.
- ROUND  out  AW+1  current sequence length, 0..MAX_LEN.
- BUSY  out  1  high in every state except IDLE, WIN and FAIL.
- WIN  out  1  level; high in WIN state.
- FAIL  out  1  level; high in FAIL state.

Behaviour:
- Reset (RST high at an edge, including mid-game):
  - State goes to IDLE.
  - All outputs are 0; ROUND=0; step index=0; timers=0.
  - LFSR is loaded with LFSR_SEED.
  - RST has priority over every other input.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It advances every non-reset cycle in every state and is never zero.
- New pattern = 8'b1 << lfsr[2:0], sampled in GEN.
- States and transitions:
  - IDLE/WIN/FAIL:
    - START → GEN, with ROUND cleared to 0.
    - BTN is ignored.
    - WIN/FAIL hold DISP at 8'hFF (WIN) or 8'h00 (FAIL).
  - GEN:
    - MEM_WE=1 for exactly 1 cycle, with MEM_ADDR=ROUND and MEM_WDATA=pattern.
    - ROUND increments.
    - Step index is cleared.
    - Next state SHOW_RD.
  - SHOW_RD: MEM_ADDR=index; next state SHOW_ON (covers the 1-cycle read latency).
  - SHOW_ON:
    - DISP latches MEM_RDATA on entry; LD=1.
    - Stays exactly SHOW_CYCLES cycles, then → SHOW_GAP.
  - SHOW_GAP:
    - DISP=0, LD=0 for exactly GAP_CYCLES cycles.
    - If index == ROUND-1: index is cleared and next state is WAIT_IN.
    - Otherwise: index increments and next state is SHOW_RD.
  - WAIT_IN:
    - DISP=0, LD=0.
    - On BTN: latch LEDS, MEM_ADDR=index, → CHECK_RD.
  - CHECK_RD: one wait cycle for read data; → CHECK.
  - CHECK:
    - Latched entry != MEM_RDATA → FAIL.
    - Match with index < ROUND-1 → index increments, back to WAIT_IN.
    - Match with index == ROUND-1 and ROUND == MAX_LEN → WIN.
    - Match with index == ROUND-1 otherwise → GEN.
- Busy-state inputs:
  - START is ignored in every busy state.
  - BTN is ignored outside WAIT_IN, including a BTN that coincides with the WAIT_IN entry cycle from SHOW_GAP.
- Simultaneous START and BTN in IDLE/WIN/FAIL: START wins.
- MEM_WE is 0 in every state except GEN. MEM_ADDR is 0 whenever it is not in use.
- Timers: one counter shared by SHOW_ON and SHOW_GAP, reloaded on every state entry. Its width is $clog2 of the largest timing parameter plus 1.
- ROUND never exceeds MAX_LEN; GEN is unreachable at ROUND == MAX_LEN.

Optional Feature:
SIMON_TIMEOUT_EN:
- Defined:
  - A counter runs in WAIT_IN and is cleared on WAIT_IN entry and on each accepted BTN.
  - Reaching TIMEOUT_CYCLES without a BTN → FAIL.
  - BTN on the same cycle as expiry is accepted; the timeout is not taken.
- Not defined: no counter is built; WAIT_IN waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan (MAX_LEN=3, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20):
- Reset → DISP=0, LD=0, MEM_WE=0, ROUND=0, BUSY=0, WIN=0, FAIL=0; hold 10 cycles with no START → no change.
- START pulse → exactly one MEM_WE cycle with MEM_ADDR=0 and one-hot MEM_WDATA=P0; ROUND=1; LD high 4 cycles with DISP=P0; then 2 cycles DISP=0; then WAIT_IN.
- Enter LEDS=P0 + BTN → GEN writes addr 1 (P1); playback shows P0 then P1, each 4 on / 2 off. Enter P0, P1; round 3 likewise; after the third correct entry → WIN=1, DISP=8'hFF, BUSY=0.
- In round 2, enter P0 then a wrong value (P1 ^ 8'h01) → FAIL=1, DISP=0. START then restarts with ROUND=1 and writes addr 0.
- BTN and START pulses during SHOW_ON/SHOW_GAP → no state change, no extra MEM_WE; RST mid-SHOW_ON → all outputs 0 on the next cycle.
- With SIMON_TIMEOUT_EN: no BTN for 20 cycles in WAIT_IN → FAIL. BTN at cycle 19 → accepted and compared normally.

Source files
------------

// File: rtl/simon_seq_ctrl.sv
// Round sequencer for the pattern-memory game: generate, play back, check.
// Optional input timeout in WAIT_IN is built when SIMON_TIMEOUT_EN is defined.
module simon_seq_ctrl #(
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 50_000_000,
  parameter int          GAP_CYCLES     = 12_500_000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 500_000_000,
  localparam int         AW = ($clog2(MAX_LEN) > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          BTN,
  input  logic [7:0]    LEDS,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [7:0]    MEM_WDATA,
  input  logic [7:0]    MEM_RDATA,
  output logic [7:0]    DISP,
  output logic          LD,
  output logic [AW:0]   ROUND,
  output logic          BUSY,
  output logic          WIN,
  output logic          FAIL
);

  localparam int TM1 = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMX = (TM1 > TIMEOUT_CYCLES) ? TM1 : TIMEOUT_CYCLES;
  localparam int TW  = $clog2(TMX) + 1;

  localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GEN,
    S_SHOW_RD,
    S_SHOW_ON,
    S_SHOW_GAP,
    S_WAIT_IN,
    S_CHECK_RD,
    S_CHECK,
    S_WIN,
    S_FAIL
  } state_e;

  state_e          state_q, state_d;
  logic [AW:0]     round_q, round_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      disp_q, disp_d;
  logic [7:0]      entry_q, entry_d;
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]   tmo_q, tmo_d;
`endif

  logic            last_step;
  logic            show_first;
  logic [7:0]      pattern;

  assign last_step  = ({1'b0, idx_q} == (round_q - (AW+1)'(1)));
  assign show_first = (timer_q == SHOW_LOAD);
  assign pattern    = 8'b1 << lfsr_q[2:0];
  assign lfsr_d     = {lfsr_q[6:0],
                       lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign ROUND      = round_q;

  // Next-state, datapath updates and all outputs, decoded from state
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    disp_d    = disp_q;
    entry_d   = entry_q;
`ifdef SIMON_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = 8'h00;
    DISP      = 8'h00;
    LD        = 1'b0;
    BUSY      = 1'b1;
    WIN       = 1'b0;
    FAIL      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          state_d = S_GEN;
          round_d = '0;
        end
      end

      S_WIN: begin
        BUSY = 1'b0;
        WIN  = 1'b1;
        DISP = 8'hFF;
        if (START) begin
          state_d = S_GEN;
          round_d = '0;
        end
      end

      S_FAIL: begin
        BUSY = 1'b0;
        FAIL = 1'b1;
        if (START) begin
          state_d = S_GEN;
          round_d = '0;
        end
      end

      S_GEN: begin
        MEM_WE    = 1'b1;
        MEM_ADDR  = round_q[AW-1:0];
        MEM_WDATA = pattern;
        round_d   = round_q + (AW+1)'(1);
        idx_d     = '0;
        state_d   = S_SHOW_RD;
      end

      S_SHOW_RD: begin
        MEM_ADDR = idx_q;
        timer_d  = SHOW_LOAD;
        state_d  = S_SHOW_ON;
      end

      // read data arrives on the first ON cycle; pass it through, then hold
      S_SHOW_ON: begin
        LD   = 1'b1;
        DISP = show_first ? MEM_RDATA : disp_q;
        if (show_first) begin
          disp_d = MEM_RDATA;
        end
        if (timer_q == '0) begin
          timer_d = GAP_LOAD;
          state_d = S_SHOW_GAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_SHOW_GAP: begin
        if (timer_q == '0) begin
          if (last_step) begin
            idx_d   = '0;
            state_d = S_WAIT_IN;
`ifdef SIMON_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_SHOW_RD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_WAIT_IN: begin
        if (BTN) begin
          entry_d  = LEDS;
          MEM_ADDR = idx_q;
          state_d  = S_CHECK_RD;
`ifdef SIMON_TIMEOUT_EN
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d  = S_FAIL;
        end else begin
          tmo_d    = tmo_q + TW'(1);
`endif
        end
      end

      S_CHECK_RD: begin
        MEM_ADDR = idx_q;
        state_d  = S_CHECK;
      end

      S_CHECK: begin
        MEM_ADDR = idx_q;
        if (entry_q != MEM_RDATA) begin
          state_d = S_FAIL;
        end else if (!last_step) begin
          idx_d   = idx_q + AW'(1);
          state_d = S_WAIT_IN;
`ifdef SIMON_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else if (round_q == (AW+1)'(MAX_LEN)) begin
          state_d = S_WIN;
        end else begin
          state_d = S_GEN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; the LFSR free-runs outside reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      round_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      lfsr_q  <= LFSR_SEED;
      disp_q  <= 8'h00;
      entry_q <= 8'h00;
`ifdef SIMON_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      disp_q  <= disp_d;
      entry_q <= entry_d;
`ifdef SIMON_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Self-checking bench for simon_seq_ctrl with a small sequence store model.
// Timeout checks are compiled in when SIMON_TIMEOUT_EN is defined.
module tb_simon_seq_ctrl;

  localparam int         ML   = 3;
  localparam int         SC   = 4;
  localparam int         GC   = 2;
  localparam int         TO   = 20;
  localparam logic [7:0] SEED = 8'hA5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       BTN = 1'b0;
  logic [7:0] LEDS = 8'h00;
  logic       MEM_WE;
  logic [1:0] MEM_ADDR;
  logic [7:0] MEM_WDATA;
  logic [7:0] MEM_RDATA;
  logic [7:0] DISP;
  logic       LD;
  logic [2:0] ROUND;
  logic       BUSY;
  logic       WIN;
  logic       FAIL;

  simon_seq_ctrl #(
    .MAX_LEN(ML),
    .SHOW_CYCLES(SC),
    .GAP_CYCLES(GC),
    .LFSR_SEED(SEED),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .BTN(BTN),
    .LEDS(LEDS),
    .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA),
    .DISP(DISP),
    .LD(LD),
    .ROUND(ROUND),
    .BUSY(BUSY),
    .WIN(WIN),
    .FAIL(FAIL)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:3];
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    MEM_RDATA = 8'h00;
  end

  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    MEM_RDATA <= mem[MEM_ADDR];
  end

  logic [7:0] mlfsr;
  always @(posedge CLK) begin
    if (RST) mlfsr <= SEED;
    else mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] seq [0:2];
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic b);
    START = s;
    BTN   = b;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    BTN   = 1'b0;
  endtask

  function automatic logic [31:0] pk(input logic busy, input logic we,
      input logic ld, input logic win, input logic fail,
      input logic [2:0] rnd, input logic [1:0] addr, input logic [7:0] disp);
    return {14'd0, busy, we, ld, win, fail, rnd, addr, disp};
  endfunction

  function automatic logic [31:0] outs();
    return {14'd0, BUSY, MEM_WE, LD, WIN, FAIL, ROUND, MEM_ADDR, DISP};
  endfunction

  task automatic gen_check(input int addr);
    logic [7:0] p;
    p = 8'b1 << mlfsr[2:0];
    chk("gen_ctrl", outs(), pk(1, 1, 0, 0, 0, 3'(addr), 2'(addr), 8'h00));
    chk("gen_wdata", {24'd0, MEM_WDATA}, {24'd0, p});
    seq[addr] = p;
  endtask

  task automatic play(input int n, input logic poke);
    logic [7:0] e;
    for (int k = 0; k < n; k++) exp_q.push_back(seq[k]);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b0);
      chk("show_rd", {29'd0, BUSY, MEM_WE, LD}, 32'b100);
      chk("show_round", {29'd0, ROUND}, 32'(n));
      e = exp_q.pop_front();
      for (int c = 0; c < SC; c++) begin
        cyc(poke, poke);
        chk("show_on", {22'd0, BUSY, MEM_WE, LD, DISP}, {22'd0, 3'b101, e});
      end
      for (int c = 0; c < GC; c++) begin
        cyc(poke, poke);
        chk("show_gap", {22'd0, BUSY, MEM_WE, LD, DISP}, {22'd0, 3'b100, 8'h00});
      end
    end
  endtask

  task automatic enter(input logic [7:0] v);
    LEDS = v;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic chk_wait(input string name, input int rnd);
    chk(name, outs(), pk(1, 0, 0, 0, 0, 3'(rnd), 2'd0, 8'h00));
  endtask

  typedef struct {
    logic       rst;
    logic       start;
    logic       btn;
    logic [7:0] leds;
    int         rep;
    logic       busy;
    logic       we;
    logic [2:0] rnd;
    string      name;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1,  1'b0, 1'b0, 3'd0, "reset"};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1,  1'b0, 1'b0, 3'd0, "rst_prio"};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 10, 1'b0, 1'b0, 3'd0, "idle_hold"};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'hFF, 1,  1'b0, 1'b0, 3'd0, "idle_btn"};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'h01, 1,  1'b1, 1'b1, 3'd0, "start_gen"};

    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        RST  = tbl[i].rst;
        LEDS = tbl[i].leds;
        cyc(tbl[i].start, tbl[i].btn);
        chk(tbl[i].name, outs(),
            pk(tbl[i].busy, tbl[i].we, 0, 0, 0, tbl[i].rnd, 2'd0, 8'h00));
      end
    end

    gen_check(0);
    play(1, 1'b1);
    LEDS = 8'h00;
    cyc(1'b0, 1'b1);
    chk_wait("wait_r1", 1);
    enter(seq[0]);
    gen_check(1);
    play(2, 1'b0);
    cyc(1'b0, 1'b0);
    enter(seq[0]);
    chk_wait("wait_r2", 2);
    enter(seq[1]);
    gen_check(2);
    play(3, 1'b1);
    cyc(1'b0, 1'b0);
    enter(seq[0]);
    enter(seq[1]);
    enter(seq[2]);
    chk("win", outs(), pk(0, 0, 0, 1, 0, 3'd3, 2'd0, 8'hFF));
    cyc(1'b0, 1'b1);
    chk("win_btn", outs(), pk(0, 0, 0, 1, 0, 3'd3, 2'd0, 8'hFF));

    cyc(1'b1, 1'b0);
    gen_check(0);
    play(1, 1'b0);
    cyc(1'b0, 1'b0);
    enter(seq[0]);
    gen_check(1);
    play(2, 1'b0);
    cyc(1'b0, 1'b0);
    enter(seq[0]);
    enter(seq[1] ^ 8'h01);
    chk("fail", outs(), pk(0, 0, 0, 0, 1, 3'd2, 2'd0, 8'h00));

    cyc(1'b1, 1'b1);
    gen_check(0);
    cyc(1'b0, 1'b0);
    chk("restart_round", {29'd0, ROUND}, 32'd1);
    cyc(1'b0, 1'b0);
    chk("restart_ld", {31'd0, LD}, 32'd1);
    RST = 1'b1;
    cyc(1'b1, 1'b1);
    chk("mid_reset", outs(), pk(0, 0, 0, 0, 0, 3'd0, 2'd0, 8'h00));
    RST = 1'b0;
    cyc(1'b1, 1'b0);
    gen_check(0);
    play(1, 1'b0);
    cyc(1'b0, 1'b0);

`ifdef SIMON_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      cyc(1'b0, 1'b0);
      chk_wait("tmo_wait", 1);
    end
    cyc(1'b0, 1'b0);
    chk("tmo_fail", outs(), pk(0, 0, 0, 0, 1, 3'd1, 2'd0, 8'h00));
    cyc(1'b1, 1'b0);
    gen_check(0);
    play(1, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 1; i < TO; i++) cyc(1'b0, 1'b0);
    chk_wait("tmo_edge", 1);
    enter(seq[0]);
    gen_check(1);
`else
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0);
    chk_wait("no_tmo", 1);
    enter(seq[0]);
    gen_check(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
